// File: rtl/idct_pkg.sv
// idct_pkg: shared mode encoding, block sizes and bank/FSM state types for the transpose scheduler.
package idct_pkg;
  localparam logic MODE_4X4 = 1'b0;
  localparam logic MODE_8X8 = 1'b1;
  localparam int N_4X4 = 16;
  localparam int N_8X8 = 64;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;
  typedef enum logic {W_IDLE, W_WRITE} wr_st_t;
  typedef enum logic {R_IDLE, R_READ} rd_st_t;
  function automatic logic [5:0] last_idx(input logic mode);
    return mode == MODE_8X8 ? 6'(N_8X8 - 1) : 6'(N_4X4 - 1);
  endfunction
endpackage

// File: rtl/tpose_addr_gen.sv
// tpose_addr_gen: maps a sample counter to a buffer address, row-major or transposed.
module tpose_addr_gen
  import idct_pkg::*;
(
  input  logic [5:0] cnt,
  input  logic       mode,
  input  logic       tpose,
  output logic [5:0] addr
);
  // 4x4 blocks use an 8-word row pitch so both modes share one buffer layout
  always_comb
    addr = mode == MODE_8X8 ? (tpose ? {cnt[2:0], cnt[5:3]} : cnt)
         : (tpose ? {1'b0, cnt[1:0], 1'b0, cnt[3:2]} : {1'b0, cnt[3:2], 1'b0, cnt[1:0]});
endmodule

// File: rtl/tpose_sched.sv
// tpose_sched: ping-pong transpose buffer scheduler for 4x4/8x8 blocks.
// Define IDCT_OVF_EN to build in the sticky overflow flag on dropped samples.
module tpose_sched
  import idct_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       mode_4_8,
  output logic       wr_en,
  output logic       wr_bank,
  output logic [5:0] wr_addr,
  output logic       rd_en,
  output logic       rd_bank,
  output logic [5:0] rd_addr,
  output logic       enable_o,
  output logic       mode_out,
  output logic       block_done,
  output logic       ovf
);
  bank_st_t   bank_st [2];
  logic [1:0] bank_mode;
  wr_st_t     ws, ws_nxt;
  rd_st_t     rs, rs_nxt;
  logic [5:0] wcnt, rcnt;
  logic       wr_ok, wmode, wlast, rmode, rlast;
  always_comb begin
    wr_ok  = bank_st[wr_bank] == EMPTY || bank_st[wr_bank] == FILLING;
    wr_en  = rst && enable_i && wr_ok;
    wmode  = ws == W_IDLE ? mode_4_8 : bank_mode[wr_bank];
    wlast  = wcnt == last_idx(wmode);
    ws_nxt = wr_en ? (wlast ? W_IDLE : W_WRITE) : ws;
    rmode  = bank_mode[rd_bank];
    // a FULL bank is read in the same cycle it is seen, so the reader never idles a cycle
    rd_en  = rs == R_READ || bank_st[rd_bank] == FULL;
    rlast  = rcnt == last_idx(rmode);
    rs_nxt = rd_en ? (rlast ? R_IDLE : R_READ) : rs;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ws         <= W_IDLE;
      rs         <= R_IDLE;
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      bank_mode  <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      enable_o   <= 1'b0;
      block_done <= 1'b0;
      mode_out   <= 1'b0;
    end else begin
      ws         <= ws_nxt;
      rs         <= rs_nxt;
      enable_o   <= rd_en;
      block_done <= rd_en && rlast;
      if (rd_en) mode_out <= rmode;
      if (wr_en) begin
        if (ws == W_IDLE) bank_mode[wr_bank] <= mode_4_8;
        bank_st[wr_bank] <= wlast ? FULL : FILLING;
        wcnt <= wlast ? 6'd0 : wcnt + 6'd1;
        if (wlast) wr_bank <= ~wr_bank;
      end
      if (rd_en) begin
        bank_st[rd_bank] <= rlast ? EMPTY : DRAINING;
        rcnt <= rlast ? 6'd0 : rcnt + 6'd1;
        if (rlast) rd_bank <= ~rd_bank;
      end
    end
  tpose_addr_gen u_wr_addr (.cnt(wcnt), .mode(wmode), .tpose(1'b0), .addr(wr_addr));
  tpose_addr_gen u_rd_addr (.cnt(rcnt), .mode(rmode), .tpose(1'b1), .addr(rd_addr));
`ifdef IDCT_OVF_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) ovf <= 1'b0;
    else if (enable_i && !wr_ok) ovf <= 1'b1;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_tpose_sched.sv
// tb_tpose_sched: scoreboard bench for tpose_sched; expected write/read/output streams are queued per block.
module tb_tpose_sched;
  logic       clk = 1'b0, rst = 1'b0, enable_i = 1'b0, mode_4_8 = 1'b0;
  logic       wr_en, wr_bank, rd_en, rd_bank, enable_o, mode_out, block_done, ovf;
  logic [5:0] wr_addr, rd_addr;
  int n_cmp = 0, n_bad = 0;
  int wq[$], rq[$], mq[$];
  int exp_bank = 0, run = 0, max_run = 0, exp_ovf;
  tpose_sched dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .mode_4_8(mode_4_8),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .enable_o(enable_o), .mode_out(mode_out), .block_done(block_done), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int wa(input int m, input int i);
    return m != 0 ? i : (i / 4) * 8 + i % 4;
  endfunction
  function automatic int ra(input int m, input int i);
    return m != 0 ? (i % 8) * 8 + i / 8 : (i % 4) * 8 + i / 4;
  endfunction
  task automatic push_block(input int m);
    int n;
    n = m != 0 ? 64 : 16;
    for (int i = 0; i < n; i++) begin
      wq.push_back(exp_bank * 64 + wa(m, i));
      rq.push_back(exp_bank * 64 + ra(m, i));
      mq.push_back(m * 2 + int'(i == n - 1));
    end
    exp_bank ^= 1;
  endtask
  task automatic drive(input int n, input logic m, input logic tog);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      enable_i = 1'b1;
      mode_4_8 = m ^ (tog && (i % 2 == 1));
    end
  endtask
  task automatic idle();
    @(posedge clk);
    #1 enable_i = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && (wq.size() + rq.size() + mq.size()) != 0; i++) @(posedge clk);
    check(tag, wq.size() + rq.size() + mq.size(), 0);
    repeat (3) @(posedge clk);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_enable_o"}, enable_o, 0);
    check({tag, "_block_done"}, block_done, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_wr_bank"}, wr_bank, 0);
    check({tag, "_rd_bank"}, rd_bank, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_mode_out"}, mode_out, 0);
  endtask
  always @(negedge clk) begin
    if (wr_en) check("wr", {wr_bank, wr_addr}, wq.size() != 0 ? wq.pop_front() : -1);
    if (rd_en) check("rd", {rd_bank, rd_addr}, rq.size() != 0 ? rq.pop_front() : -1);
    if (enable_o) check("out", {mode_out, block_done}, mq.size() != 0 ? mq.pop_front() : -1);
    else if (block_done) check("done_stray", block_done, 0);
    run = enable_o ? run + 1 : 0;
    if (run > max_run) max_run = run;
  end
  initial begin
`ifdef IDCT_OVF_EN
    exp_ovf = 1;
`else
    exp_ovf = 0;
`endif
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 1'b1;
    push_block(1);
    drive(64, 1'b1, 1'b0);
    idle();
    wait_idle("drain_8x8");
    check("mode_hold_8x8", mode_out, 1);
    push_block(0);
    drive(16, 1'b0, 1'b0);
    idle();
    wait_idle("drain_4x4");
    check("mode_hold_4x4", mode_out, 0);
    max_run = 0;
    push_block(0);
    push_block(1);
    push_block(0);
    drive(16, 1'b0, 1'b0);
    drive(64, 1'b1, 1'b0);
    drive(16, 1'b0, 1'b0);
    idle();
    wait_idle("drain_alt");
    check("b2b_run", max_run, 80);
    check("ovf_alt", ovf, 0);
    push_block(0);
    drive(16, 1'b0, 1'b1);
    idle();
    wait_idle("drain_toggle");
    check("ovf_toggle", ovf, 0);
    push_block(1);
    push_block(0);
    push_block(1);
    drive(64, 1'b1, 1'b0);
    drive(16, 1'b0, 1'b0);
    drive(112, 1'b1, 1'b0);
    idle();
    wait_idle("drain_ovf");
    check("ovf_drop", ovf, exp_ovf);
    push_block(1);
    drive(30, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_zero("midrst");
    enable_i = 1'b0;
    wq.delete();
    rq.delete();
    mq.delete();
    exp_bank = 0;
    @(negedge clk) rst = 1'b1;
    push_block(1);
    drive(64, 1'b1, 1'b0);
    idle();
    wait_idle("drain_post_rst");
    check("mode_post_rst", mode_out, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
